// File: rtl/cmd_cfg_pkg.sv
// Shared opcodes, FSM states, register addresses, response codes and reset values
// for the capture-unit command/config block.
package cmd_cfg_pkg;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_DMP = 2'b10,
    OP_RSV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    RESP_WAIT,
    DUMP_LD,
    DUMP_WAIT
  } state_e;

  localparam logic [5:0] A_TRIG_CFG = 6'h00;
  localparam logic [5:0] A_DECIM    = 6'h20;
  localparam logic [5:0] A_VIH      = 6'h21;
  localparam logic [5:0] A_VIL      = 6'h22;
  localparam logic [5:0] A_MATCH_H  = 6'h23;
  localparam logic [5:0] A_MATCH_L  = 6'h24;
  localparam logic [5:0] A_MASK_H   = 6'h25;
  localparam logic [5:0] A_MASK_L   = 6'h26;
  localparam logic [5:0] A_BAUD_H   = 6'h27;
  localparam logic [5:0] A_BAUD_L   = 6'h28;
  localparam logic [5:0] A_TPOS_H   = 6'h29;
  localparam logic [5:0] A_TPOS_L   = 6'h2A;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  localparam logic [5:0]  TRIG_CFG_RST = 6'h03;
  localparam logic [4:0]  CH_TRIG_RST  = 5'h01;
  localparam logic [3:0]  DECIM_RST    = 4'h0;
  localparam logic [7:0]  VIH_RST      = 8'hAA;
  localparam logic [7:0]  VIL_RST      = 8'h55;
  localparam logic [15:0] MATCH_RST    = 16'h0000;
  localparam logic [15:0] MASK_RST     = 16'h0000;
  localparam logic [15:0] BAUD_RST     = 16'h06C8;
  localparam logic [15:0] TPOS_RST     = 16'h0001;

endpackage

// File: rtl/cfg_regfile.sv
// Trigger/analog/baud register set: write decode, zero-extended read mux, mapped flag.
// CMD_CFG_TIMEOUT_EN turns trig_cfg[4] into a sticky timeout flag cleared by host writes.
module cfg_regfile
  import cmd_cfg_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int LOG2   = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            i_addr,
  input  logic [7:0]            i_wdata,
  input  logic                  i_wr,
  input  logic                  i_set_capture_done,
`ifdef CMD_CFG_TIMEOUT_EN
  input  logic                  i_to_set,
`endif
  output logic [7:0]            o_rdata,
  output logic                  o_mapped,
  output logic [5:0]            o_trig_cfg,
  output logic [5*NUM_CH-1:0]   o_ch_trig_cfg,
  output logic [3:0]            o_decimator,
  output logic [7:0]            o_vih,
  output logic [7:0]            o_vil,
  output logic [15:0]           o_match,
  output logic [15:0]           o_mask,
  output logic [15:0]           o_baud_cnt,
  output logic [LOG2-1:0]       o_trig_pos
);

  logic [5:0]      r_trig_cfg;
  logic [4:0]      r_ch_trig [NUM_CH];
  logic [3:0]      r_decim;
  logic [7:0]      r_vih;
  logic [7:0]      r_vil;
  logic [15:0]     r_match;
  logic [15:0]     r_mask;
  logic [15:0]     r_baud;
  logic [LOG2-1:0] r_trig_pos;

  logic [15:0]     w_tpos16;
  logic [LOG2-1:0] w_tpos_hwr;
  logic [LOG2-1:0] w_tpos_lwr;

  // trig_pos is handled as a zero-extended 16-bit value so H/L halves work for any LOG2
  assign w_tpos16   = 16'(r_trig_pos);
  assign w_tpos_hwr = LOG2'({i_wdata, w_tpos16[7:0]});
  assign w_tpos_lwr = LOG2'({w_tpos16[15:8], i_wdata});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_cfg <= TRIG_CFG_RST;
      for (int k = 0; k < NUM_CH; k++) r_ch_trig[k] <= CH_TRIG_RST;
      r_decim    <= DECIM_RST;
      r_vih      <= VIH_RST;
      r_vil      <= VIL_RST;
      r_match    <= MATCH_RST;
      r_mask     <= MASK_RST;
      r_baud     <= BAUD_RST;
      r_trig_pos <= LOG2'(TPOS_RST);
    end else begin
      if (i_wr && (i_addr == A_TRIG_CFG)) begin
`ifdef CMD_CFG_TIMEOUT_EN
        r_trig_cfg <= {i_wdata[5] | i_set_capture_done, 1'b0, i_wdata[3:0]};
`else
        r_trig_cfg <= {i_wdata[5] | i_set_capture_done, i_wdata[4:0]};
`endif
      end else begin
        if (i_set_capture_done) r_trig_cfg[5] <= 1'b1;
`ifdef CMD_CFG_TIMEOUT_EN
        if (i_to_set) r_trig_cfg[4] <= 1'b1;
`endif
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_wr && (i_addr == 6'(k + 1))) r_ch_trig[k] <= i_wdata[4:0];
      end
      if (i_wr) begin
        case (i_addr)
          A_DECIM:   r_decim        <= i_wdata[3:0];
          A_VIH:     r_vih          <= i_wdata;
          A_VIL:     r_vil          <= i_wdata;
          A_MATCH_H: r_match[15:8]  <= i_wdata;
          A_MATCH_L: r_match[7:0]   <= i_wdata;
          A_MASK_H:  r_mask[15:8]   <= i_wdata;
          A_MASK_L:  r_mask[7:0]    <= i_wdata;
          A_BAUD_H:  r_baud[15:8]   <= i_wdata;
          A_BAUD_L:  r_baud[7:0]    <= i_wdata;
          A_TPOS_H:  r_trig_pos     <= w_tpos_hwr;
          A_TPOS_L:  r_trig_pos     <= w_tpos_lwr;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata  = 8'h00;
    o_mapped = 1'b1;
    case (i_addr)
      A_TRIG_CFG: o_rdata = {2'b00, r_trig_cfg};
      A_DECIM:    o_rdata = {4'h0, r_decim};
      A_VIH:      o_rdata = r_vih;
      A_VIL:      o_rdata = r_vil;
      A_MATCH_H:  o_rdata = r_match[15:8];
      A_MATCH_L:  o_rdata = r_match[7:0];
      A_MASK_H:   o_rdata = r_mask[15:8];
      A_MASK_L:   o_rdata = r_mask[7:0];
      A_BAUD_H:   o_rdata = r_baud[15:8];
      A_BAUD_L:   o_rdata = r_baud[7:0];
      A_TPOS_H:   o_rdata = w_tpos16[15:8];
      A_TPOS_L:   o_rdata = w_tpos16[7:0];
      default:    o_mapped = 1'b0;
    endcase
    // Channel registers sit at 1..NUM_CH, which the case above leaves unmapped
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_addr == 6'(k + 1)) begin
        o_rdata  = {3'b000, r_ch_trig[k]};
        o_mapped = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
    assign o_ch_trig_cfg[5*g +: 5] = r_ch_trig[g];
  end

  assign o_trig_cfg  = r_trig_cfg;
  assign o_decimator = r_decim;
  assign o_vih       = r_vih;
  assign o_vil       = r_vil;
  assign o_match     = r_match;
  assign o_mask      = r_mask;
  assign o_baud_cnt  = r_baud;
  assign o_trig_pos  = r_trig_pos;

endmodule

// File: rtl/cmd_cfg_n.sv
// Host command decoder (RD/WR/DMP, ACK/NAK): send_resp 1 cycle after accept, clr_cmd_rdy registered off resp_sent.
// Each response is held until resp_sent; CMD_CFG_TIMEOUT_EN adds a TO_CYC response timeout.
module cmd_cfg_n
  import cmd_cfg_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int LOG2   = 9
`ifdef CMD_CFG_TIMEOUT_EN
  , parameter int TO_CYC = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           cmd,
  input  logic                  cmd_rdy,
  input  logic                  resp_sent,
  input  logic                  rd_done,
  input  logic                  set_capture_done,
  input  logic [8*NUM_CH-1:0]   rdata,
  output logic [5:0]            trig_cfg,
  output logic [5*NUM_CH-1:0]   ch_trig_cfg,
  output logic [3:0]            decimator,
  output logic [7:0]            vih,
  output logic [7:0]            vil,
  output logic [15:0]           match,
  output logic [15:0]           mask,
  output logic [15:0]           baud_cnt,
  output logic [LOG2-1:0]       trig_pos,
  output logic [7:0]            resp,
  output logic                  send_resp,
  output logic                  clr_cmd_rdy,
  output logic                  strt_rd
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_resp;
  logic        r_send_resp;
  logic        r_clr_cmd_rdy;
  logic        r_strt_rd;
  logic [3:0]  r_ch_idx;

  opcode_e     w_op;
  logic [5:0]  w_addr;
  logic [7:0]  w_data;
  logic [7:0]  w_rdata;
  logic        w_mapped;
  logic        w_ch_ok;
  logic [7:0]  w_dump_byte;
  logic [7:0]  w_resp_nxt;
  logic        w_send;
  logic        w_clr;
  logic        w_strt;
  logic        w_wr;
  logic        w_ch_ld;

  assign w_op    = opcode_e'(cmd[15:14]);
  assign w_addr  = cmd[13:8];
  assign w_data  = cmd[7:0];
  assign w_ch_ok = (w_addr != 6'd0) && (w_addr <= 6'(NUM_CH));

`ifdef CMD_CFG_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        w_to_hit;
  logic        w_to;

  assign w_to_hit = (r_to_cnt == 16'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= 16'd0;
    end else if ((w_state_nxt != r_state) ||
                 !((r_state == RESP_WAIT) || (r_state == DUMP_WAIT))) begin
      r_to_cnt <= 16'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`endif

  cfg_regfile #(
    .NUM_CH (NUM_CH),
    .LOG2   (LOG2)
  ) u_regfile (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_addr             (w_addr),
    .i_wdata            (w_data),
    .i_wr               (w_wr),
    .i_set_capture_done (set_capture_done),
`ifdef CMD_CFG_TIMEOUT_EN
    .i_to_set           (w_to),
`endif
    .o_rdata            (w_rdata),
    .o_mapped           (w_mapped),
    .o_trig_cfg         (trig_cfg),
    .o_ch_trig_cfg      (ch_trig_cfg),
    .o_decimator        (decimator),
    .o_vih              (vih),
    .o_vil              (vil),
    .o_match            (match),
    .o_mask             (mask),
    .o_baud_cnt         (baud_cnt),
    .o_trig_pos         (trig_pos)
  );

  always_comb begin
    w_dump_byte = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch_idx == 4'(k)) w_dump_byte = rdata[8*k +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_resp_nxt  = r_resp;
    w_send      = 1'b0;
    w_clr       = 1'b0;
    w_strt      = 1'b0;
    w_wr        = 1'b0;
    w_ch_ld     = 1'b0;
`ifdef CMD_CFG_TIMEOUT_EN
    w_to        = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // cmd_rdy is still high while clr_cmd_rdy is out; don't take the old command twice
        if (cmd_rdy && !r_clr_cmd_rdy) begin
          w_resp_nxt  = NAK;
          w_send      = 1'b1;
          w_state_nxt = RESP_WAIT;
          case (w_op)
            OP_RD: if (w_mapped) w_resp_nxt = w_rdata;
            OP_WR: if (w_mapped) begin
              w_wr       = 1'b1;
              w_resp_nxt = ACK;
            end
            OP_DMP: if (w_ch_ok) begin
              w_resp_nxt  = r_resp;
              w_send      = 1'b0;
              w_strt      = 1'b1;
              w_ch_ld     = 1'b1;
              w_state_nxt = DUMP_LD;
            end
            OP_RSV: ;
          endcase
        end
      end
      RESP_WAIT: begin
        if (resp_sent) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end
`ifdef CMD_CFG_TIMEOUT_EN
        else if (w_to_hit) begin
          w_clr       = 1'b1;
          w_to        = 1'b1;
          w_state_nxt = IDLE;
        end
`endif
      end
      DUMP_LD: begin
        // Give the RAM reader the strt_rd cycle to present the first byte
        if (!r_strt_rd) begin
          if (rd_done) begin
            w_clr       = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_resp_nxt  = w_dump_byte;
            w_send      = 1'b1;
            w_state_nxt = DUMP_WAIT;
          end
        end
      end
      DUMP_WAIT: begin
        if (resp_sent) begin
          w_state_nxt = DUMP_LD;
        end
`ifdef CMD_CFG_TIMEOUT_EN
        else if (w_to_hit) begin
          w_clr       = 1'b1;
          w_to        = 1'b1;
          w_state_nxt = IDLE;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp        <= 8'h00;
      r_send_resp   <= 1'b0;
      r_clr_cmd_rdy <= 1'b0;
      r_strt_rd     <= 1'b0;
      r_ch_idx      <= 4'd0;
    end else begin
      r_resp        <= w_resp_nxt;
      r_send_resp   <= w_send;
      r_clr_cmd_rdy <= w_clr;
      r_strt_rd     <= w_strt;
      if (w_ch_ld) r_ch_idx <= 4'(w_addr - 6'd1);
    end
  end

  assign resp        = r_resp;
  assign send_resp   = r_send_resp;
  assign clr_cmd_rdy = r_clr_cmd_rdy;
  assign strt_rd     = r_strt_rd;

endmodule

// File: tb/tb_cmd_cfg_n.sv
// Scoreboarded bench for cmd_cfg_n: directed and random commands against a register-image model.
`timescale 1ns/1ps
module tb_cmd_cfg_n;
  localparam int NUM_CH = 5;
  localparam int LOG2   = 9;
  localparam logic [7:0] ACK_B = 8'hA5;
  localparam logic [7:0] NAK_B = 8'hEE;

  logic                clk;
  logic                rst_n;
  logic [15:0]         cmd;
  logic                cmd_rdy;
  logic                resp_sent;
  logic                rd_done;
  logic                set_capture_done;
  logic [8*NUM_CH-1:0] rdata;
  logic [5:0]          trig_cfg;
  logic [5*NUM_CH-1:0] ch_trig_cfg;
  logic [3:0]          decimator;
  logic [7:0]          vih, vil;
  logic [15:0]         match, mask, baud_cnt;
  logic [LOG2-1:0]     trig_pos;
  logic [7:0]          resp;
  logic                send_resp, clr_cmd_rdy, strt_rd;

  cmd_cfg_n #(.NUM_CH(NUM_CH), .LOG2(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
    .rd_done(rd_done), .set_capture_done(set_capture_done), .rdata(rdata),
    .trig_cfg(trig_cfg), .ch_trig_cfg(ch_trig_cfg), .decimator(decimator),
    .vih(vih), .vil(vil), .match(match), .mask(mask), .baud_cnt(baud_cnt),
    .trig_pos(trig_pos), .resp(resp), .send_resp(send_resp),
    .clr_cmd_rdy(clr_cmd_rdy), .strt_rd(strt_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_sent   = 0;
  int n_acked  = 0;
  int n_strt   = 0;

  logic [7:0] m_reg [64];
  logic [7:0] exp_q [$];

  logic [7:0] ram_seq [8];
  int         ram_len = 0;
  int         ram_ch  = 0;
  int         ram_idx = 0;
  bit         ram_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_mapped(input logic [5:0] a);
    return (a <= 6'(NUM_CH)) || ((a >= 6'h20) && (a <= 6'h2A));
  endfunction

  function automatic logic [7:0] wmask(input logic [5:0] a);
    if (a == 6'h00) return 8'h3F;
    if (a <= 6'(NUM_CH)) return 8'h1F;
    if (a == 6'h20) return 8'h0F;
    if (a == 6'h29) return 8'hFF >> (16 - LOG2);
    return 8'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[0] = 8'h03;
    for (int i = 1; i <= NUM_CH; i++) m_reg[i] = 8'h01;
    m_reg[6'h21] = 8'hAA;
    m_reg[6'h22] = 8'h55;
    m_reg[6'h27] = 8'h06;
    m_reg[6'h28] = 8'hC8;
    m_reg[6'h2A] = 8'h01;
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] tp;
    tp = {m_reg[6'h29], m_reg[6'h2A]};
    check({tag, "_trig_cfg"}, 32'(trig_cfg), 32'(m_reg[0][5:0]));
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("%s_ch%0d_trig_cfg", tag, k + 1), 32'(ch_trig_cfg[5*k +: 5]), 32'(m_reg[k + 1][4:0]));
    check({tag, "_decimator"}, 32'(decimator), 32'(m_reg[6'h20][3:0]));
    check({tag, "_vih"}, 32'(vih), 32'(m_reg[6'h21]));
    check({tag, "_vil"}, 32'(vil), 32'(m_reg[6'h22]));
    check({tag, "_match"}, 32'(match), 32'({m_reg[6'h23], m_reg[6'h24]}));
    check({tag, "_mask"}, 32'(mask), 32'({m_reg[6'h25], m_reg[6'h26]}));
    check({tag, "_baud_cnt"}, 32'(baud_cnt), 32'({m_reg[6'h27], m_reg[6'h28]}));
    check({tag, "_trig_pos"}, 32'(trig_pos), 32'(tp[LOG2-1:0]));
  endtask

  // Environment: scoreboard monitor, UART transmitter (resp_sent) and channel-RAM reader
  int resp_delay = 0;
  bit resp_pending = 1'b0;
  initial begin
    resp_sent = 1'b0;
    rd_done   = 1'b0;
    rdata     = '0;
    forever begin
      @(negedge clk);
      if (resp_sent) begin
        resp_sent = 1'b0;
        if (ram_active) ram_idx++;
      end
      if (rst_n) begin
        if (send_resp) begin
          n_sent++;
          check("send_resp_expected", 32'(send_resp), 32'(exp_q.size() > 0));
          if (exp_q.size() > 0) check("resp_byte", 32'(resp), 32'(exp_q.pop_front()));
          resp_delay   = $urandom_range(0, 3);
          resp_pending = 1'b1;
        end
        if (resp_pending) begin
          if (resp_delay == 0) begin
            resp_sent    = 1'b1;
            n_acked++;
            resp_pending = 1'b0;
          end else begin
            resp_delay--;
          end
        end
        if (clr_cmd_rdy) begin
          check("clr_after_resp_sent", 32'(n_acked), 32'(n_sent));
          ram_active = 1'b0;
        end
        if (strt_rd) begin
          n_strt++;
          ram_active = 1'b1;
          ram_idx    = 0;
        end
      end
      for (int k = 0; k < NUM_CH; k++)
        rdata[8*k +: 8] = (ram_active && (k == ram_ch - 1) && (ram_idx < ram_len)) ?
                          ram_seq[ram_idx] : 8'(8'hC0 + k);
      rd_done = ram_active && (ram_idx >= ram_len);
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d,
                        input bit capdone, input int dlen, input bit preset);
    int strt_before;
    int exp_strt;
    int w;
    exp_strt = 0;
    case (op)
      2'b00: exp_q.push_back(is_mapped(a) ? m_reg[a] : NAK_B);
      2'b01: begin
        if (is_mapped(a)) begin
          m_reg[a] = d & wmask(a);
          exp_q.push_back(ACK_B);
        end else begin
          exp_q.push_back(NAK_B);
        end
      end
      2'b10: begin
        if ((a >= 6'd1) && (a <= 6'(NUM_CH))) begin
          exp_strt = 1;
          ram_ch   = int'(a);
          ram_len  = dlen;
          for (int i = 0; i < dlen; i++) begin
            if (!preset) ram_seq[i] = 8'($urandom);
            exp_q.push_back(ram_seq[i]);
          end
        end else begin
          exp_q.push_back(NAK_B);
        end
      end
      default: exp_q.push_back(NAK_B);
    endcase
    if (capdone) m_reg[0] = m_reg[0] | 8'h20;
    strt_before = n_strt;
    @(negedge clk);
    cmd = {op, a, d};
    cmd_rdy = 1'b1;
    set_capture_done = capdone;
    @(negedge clk);
    set_capture_done = 1'b0;
    check_regs("post_accept");
    w = 0;
    while (!clr_cmd_rdy && (w < 300)) begin
      @(negedge clk);
      w++;
    end
    check("clr_cmd_rdy_seen", 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    @(negedge clk);
    check("strt_rd_count", 32'(n_strt - strt_before), 32'(exp_strt));
    check("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    check_regs("post_cmd");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    logic [5:0] a;
    int         r;
    rst_n = 1'b0;
    cmd = 16'h0000;
    cmd_rdy = 1'b0;
    set_capture_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp", 32'(resp), 32'h00);
    check("rst_send_resp", 32'(send_resp), 32'd0);
    check("rst_clr_cmd_rdy", 32'(clr_cmd_rdy), 32'd0);
    check("rst_strt_rd", 32'(strt_rd), 32'd0);
    check_regs("rst");

    do_cmd(2'b00, 6'h27, 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b00, 6'h28, 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b01, 6'h22, 8'h40, 1'b0, 0, 1'b0);
    check("vil_written", 32'(vil), 32'h40);
    do_cmd(2'b00, 6'h22, 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b00, 6'h15, 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b01, 6'h3F, 8'h77, 1'b0, 0, 1'b0);
    do_cmd(2'b11, 6'h21, 8'h12, 1'b0, 0, 1'b0);
    ram_seq[0] = 8'h11; ram_seq[1] = 8'h22; ram_seq[2] = 8'h33;
    do_cmd(2'b10, 6'd3, 8'h00, 1'b0, 3, 1'b1);
    do_cmd(2'b10, 6'd0, 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b10, 6'(NUM_CH + 1), 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b10, 6'(NUM_CH), 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b01, 6'h00, 8'h05, 1'b1, 0, 1'b0);
    check("trig_cfg_wr_with_capdone", 32'(trig_cfg), 32'h25);
    do_cmd(2'b01, 6'h29, 8'hFF, 1'b0, 0, 1'b0);
    do_cmd(2'b00, 6'h29, 8'h00, 1'b0, 0, 1'b0);
    do_cmd(2'b01, 6'(NUM_CH), 8'hFF, 1'b0, 0, 1'b0);
    do_cmd(2'b00, 6'h21, 8'h00, 1'b1, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, NUM_CH + 11);
        a = (r <= NUM_CH) ? 6'(r) : 6'(32 + r - NUM_CH - 1);
      end else begin
        a = 6'($urandom_range(0, 63));
      end
      do_cmd(op, a, 8'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 4), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
